// File: rtl/cpu_pkg.sv
// Shared CPU constants: register index width, datapath width and the register index type.
package cpu_pkg;
    localparam int REG_ADDR_W = 3;
    localparam int DATA_W     = 8;
    typedef logic [REG_ADDR_W-1:0] reg_idx_t;
endpackage

// File: rtl/operand_bypass.sv
// Priority select for one source operand: live write-back, issue-cycle write, RF data, held value.
// With ZERO_REG_EN defined, register 0 always reads as zero.
module operand_bypass
    import cpu_pkg::*;
#(
    parameter int BUS_WIDTH  = DATA_W,
    parameter int ADDR_WIDTH = REG_ADDR_W
) (
    input  logic                  wb_we_i,
    input  logic [ADDR_WIDTH-1:0] wb_addr_i,
    input  logic [BUS_WIDTH-1:0]  wb_data_i,
    input  logic                  fresh_i,
    input  logic                  lw_valid_i,
    input  logic [ADDR_WIDTH-1:0] lw_addr_i,
    input  logic [BUS_WIDTH-1:0]  lw_data_i,
    input  logic [ADDR_WIDTH-1:0] rs_i,
    input  logic [BUS_WIDTH-1:0]  rf_data_i,
    input  logic [BUS_WIDTH-1:0]  held_i,
    output logic [BUS_WIDTH-1:0]  op_o
);

    always_comb begin
        op_o = held_i;
        if (wb_we_i && (wb_addr_i == rs_i)) begin
            op_o = wb_data_i;
        end else if (fresh_i && lw_valid_i && (lw_addr_i == rs_i)) begin
            // RF read-before-write returned the old value on the issue cycle
            op_o = lw_data_i;
        end else if (fresh_i) begin
            op_o = rf_data_i;
        end
`ifdef ZERO_REG_EN
        if (rs_i == '0) begin
            op_o = '0;
        end
`endif
    end

endmodule

// File: rtl/operand_fetch.sv
// Register-read stage: drives RF read addresses, captures and bypass-corrects operands for execute.
// Optional macro ZERO_REG_EN makes register 0 a hard-wired zero.
module operand_fetch
    import cpu_pkg::*;
#(
    parameter int BUS_WIDTH  = DATA_W,
    parameter int ADDR_WIDTH = REG_ADDR_W,
    parameter int TAG_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_rs_a,
    input  logic [ADDR_WIDTH-1:0] in_rs_b,
    input  logic [TAG_WIDTH-1:0]  in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BUS_WIDTH-1:0]  out_op_a,
    output logic [BUS_WIDTH-1:0]  out_op_b,
    output logic [TAG_WIDTH-1:0]  out_tag,
    input  logic                  wb_we,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic [BUS_WIDTH-1:0]  wb_data,
    output logic                  rf_we,
    output logic [ADDR_WIDTH-1:0] rf_wr_addr,
    output logic [BUS_WIDTH-1:0]  rf_wr_data,
    output logic [ADDR_WIDTH-1:0] rf_rd_addr_a,
    output logic [ADDR_WIDTH-1:0] rf_rd_addr_b,
    input  logic [BUS_WIDTH-1:0]  rf_rd_data_a,
    input  logic [BUS_WIDTH-1:0]  rf_rd_data_b
);

    logic                  s_valid_q, s_valid_d;
    logic                  s_fresh_q, s_fresh_d;
    logic [ADDR_WIDTH-1:0] s_rs_a_q, s_rs_a_d;
    logic [ADDR_WIDTH-1:0] s_rs_b_q, s_rs_b_d;
    logic [TAG_WIDTH-1:0]  s_tag_q, s_tag_d;
    logic [BUS_WIDTH-1:0]  h_a_q, h_a_d;
    logic [BUS_WIDTH-1:0]  h_b_q, h_b_d;
    logic                  lw_valid_q;
    logic [ADDR_WIDTH-1:0] lw_addr_q;
    logic [BUS_WIDTH-1:0]  lw_data_q;

    logic                  wb_eff;
    logic                  xfer;
    logic [BUS_WIDTH-1:0]  op_a, op_b;

`ifdef ZERO_REG_EN
    assign wb_eff = wb_we && (wb_addr != '0);
`else
    assign wb_eff = wb_we;
`endif

    assign rf_we        = wb_eff;
    assign rf_wr_addr   = wb_addr;
    assign rf_wr_data   = wb_data;
    assign rf_rd_addr_a = in_rs_a;
    assign rf_rd_addr_b = in_rs_b;

    assign in_ready  = !s_valid_q || out_ready;
    assign xfer      = in_valid && in_ready;
    assign out_valid = s_valid_q;
    assign out_tag   = s_tag_q;
    assign out_op_a  = op_a;
    assign out_op_b  = op_b;

    operand_bypass #(
        .BUS_WIDTH  (BUS_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_byp_a (
        .wb_we_i    (wb_we),
        .wb_addr_i  (wb_addr),
        .wb_data_i  (wb_data),
        .fresh_i    (s_fresh_q),
        .lw_valid_i (lw_valid_q),
        .lw_addr_i  (lw_addr_q),
        .lw_data_i  (lw_data_q),
        .rs_i       (s_rs_a_q),
        .rf_data_i  (rf_rd_data_a),
        .held_i     (h_a_q),
        .op_o       (op_a)
    );

    operand_bypass #(
        .BUS_WIDTH  (BUS_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_byp_b (
        .wb_we_i    (wb_we),
        .wb_addr_i  (wb_addr),
        .wb_data_i  (wb_data),
        .fresh_i    (s_fresh_q),
        .lw_valid_i (lw_valid_q),
        .lw_addr_i  (lw_addr_q),
        .lw_data_i  (lw_data_q),
        .rs_i       (s_rs_b_q),
        .rf_data_i  (rf_rd_data_b),
        .held_i     (h_b_q),
        .op_o       (op_b)
    );

    // Without a new transfer the held operands keep snooping write-back every cycle
    always_comb begin
        s_valid_d = s_valid_q;
        s_fresh_d = 1'b0;
        s_rs_a_d  = s_rs_a_q;
        s_rs_b_d  = s_rs_b_q;
        s_tag_d   = s_tag_q;
        h_a_d     = op_a;
        h_b_d     = op_b;
        if (xfer) begin
            s_valid_d = 1'b1;
            s_fresh_d = 1'b1;
            s_rs_a_d  = in_rs_a;
            s_rs_b_d  = in_rs_b;
            s_tag_d   = in_tag;
            h_a_d     = h_a_q;
            h_b_d     = h_b_q;
        end else if (s_valid_q && out_ready) begin
            s_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_valid_q  <= 1'b0;
            s_fresh_q  <= 1'b0;
            s_rs_a_q   <= '0;
            s_rs_b_q   <= '0;
            s_tag_q    <= '0;
            h_a_q      <= '0;
            h_b_q      <= '0;
            lw_valid_q <= 1'b0;
            lw_addr_q  <= '0;
            lw_data_q  <= '0;
        end else begin
            s_valid_q  <= s_valid_d;
            s_fresh_q  <= s_fresh_d;
            s_rs_a_q   <= s_rs_a_d;
            s_rs_b_q   <= s_rs_b_d;
            s_tag_q    <= s_tag_d;
            h_a_q      <= h_a_d;
            h_b_q      <= h_b_d;
            lw_valid_q <= wb_eff;
            lw_addr_q  <= wb_addr;
            lw_data_q  <= wb_data;
        end
    end

endmodule
